epl_correlator: RTL and testbench
=================================

EPL_CORRELATOR -- requirements
Module: epl_correlator

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- ch_enable  in  1  channel enable.
- acc_clear  in  1  one-cycle pulse; clears the pipeline and accumulators.
- sample_enable  in  1  one-cycle pulse; IF and carrier inputs are valid this cycle.
- if_sign, if_mag  in  1,1  IF sample: sign 0 means +, sign 1 means -; mag 0 means 1, mag 1 means 3.
- car_i_sign, car_i_mag  in  1,1  carrier I: sign 0 means +, sign 1 means -; mag 0 means 1, mag 1 means 2.
- car_q_sign, car_q_mag  in  1,1  carrier Q, same encoding as carrier I.
- early, prompt, late  in  1 each  code chips from the code generator: 0 means +1, 1 means -1.
- dump_enable  in  1  one-cycle pulse marking the C/A code epoch.
- status_read  in  1  one-cycle pulse; acknowledges the latched results.
- i_early, q_early, i_prompt, q_prompt, i_late, q_late  out  16 each  latched accumulations, signed two's complement.
- sample_count  out  16  number of samples in the latched interval, saturating at 65535.
- new_data  out  1  results are latched and not yet read.
- overrun  out  1  a latch occurred while new_data was already set; sticky.

Function
REQ-002 Stage 1: on sample_enable, the block SHALL register the following:
- mix_i = IF x carrier I; mix_q = IF x carrier Q.
- Each product is signed, range -6..+6, 4 bits.
- early, prompt and late are registered in the same cycle.
- A stage-1 valid bit is set.
REQ-003 Stage 2: for each valid stage-1 entry, the block SHALL add mix_i and mix_q, each multiplied by the registered code sign, to the six 16-bit accumulators.
REQ-004 Accumulator addition SHALL saturate at +32767 and -32768; it SHALL NOT wrap.
REQ-005 dump_enable SHALL be delayed one cycle (dump_d) so that it aligns with stage 1.
REQ-006 A sample whose sample_enable coincides with dump_enable SHALL be the first sample of the new interval.
REQ-007 On dump_d, the block SHALL perform these actions in the same clock edge:
- Copy the accumulators, excluding the current stage-1 entry, to the outputs.
- Copy the interval sample counter to sample_count.
- Load the accumulators with the current stage-1 contribution, or with 0 if stage 1 is not valid.
- Load the sample counter with 1 if stage 1 is valid, otherwise 0.
REQ-008 Output registers, new_data and overrun SHALL update exactly 2 clocks after the dump_enable cycle, that is, visible from cycle t+2 for a dump in cycle t.
REQ-009 The block SHALL set new_data on every latch and clear it on status_read.
REQ-010 overrun SHALL set on a latch while new_data is 1 and status_read is 0; it SHALL clear only on status_read.
REQ-011 If status_read and a latch coincide, the result SHALL be new_data=1 and overrun=0.
REQ-012 While ch_enable=0, stage valids, accumulators and the counter SHALL be held at 0 and dump_d SHALL be ignored; outputs, new_data and overrun SHALL hold.
REQ-013 acc_clear SHALL zero stage 1, the accumulators, the counter and the dump delay in the next cycle; outputs and flags SHALL be unaffected. acc_clear SHALL have priority over sample_enable and dump_enable in the same cycle.
REQ-014 Back-to-back sample_enable on every clock SHALL be supported with no lost samples.
REQ-015 Latency from sample_enable to the accumulator update SHALL be 2 clocks.

Reset
REQ-016 When rst=1, all registers SHALL clear to 0 on the next edge. This includes all outputs, new_data, overrun, stage valids and dump_d.
REQ-017 rst SHALL have priority over acc_clear, ch_enable and all pulses.
REQ-018 A rst asserted mid-interval SHALL discard the partial interval; no latch SHALL occur for it.

Verification
REQ-019 Basic accumulation: IF=+3, carrier I=+2, carrier Q=+1, all chips 0, 10 samples, then dump_enable → all i_* = 60, all q_* = 30, sample_count = 10, new_data = 1 at t+2.
REQ-020 Code sign and alignment:
- Same stimulus with late=1 → i_late = -60, q_late = -30; E/P unchanged.
- A sample coinciding with dump_enable → counted in the next interval; the next dump gives sample_count = 1.
REQ-021 Saturation: 6000 samples of IF=+3, carrier I=+2 (mix_i = +6, total 36000) → i_* = 32767. The same with IF = -3 → i_* = -32768.
REQ-022 Flags: two dumps with no status_read → overrun = 1. status_read → new_data = 0, overrun = 0. status_read coincident with a latch → new_data = 1, overrun = 0.
REQ-023 Control inputs:
- rst asserted after 5 samples → all outputs 0, no latch at the next dump.
- acc_clear after 5 samples, then 3 samples and a dump → sample_count = 3.
- ch_enable = 0 → outputs hold through dumps.

Source files
------------

// File: rtl/epl_correlator_if.sv
// Channel-side bundle for the early/prompt/late correlator: sample, code and
// control strobes in, latched correlation results and status flags out.
interface epl_correlator_if;
   logic        ch_enable;
   logic        acc_clear;
   logic        sample_enable;
   logic        if_sign, if_mag;
   logic        car_i_sign, car_i_mag;
   logic        car_q_sign, car_q_mag;
   logic        early, prompt, late;
   logic        dump_enable;
   logic        status_read;
   logic [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
   logic [15:0] sample_count;
   logic        new_data;
   logic        overrun;

   modport master (
      output ch_enable, acc_clear, sample_enable, if_sign, if_mag,
             car_i_sign, car_i_mag, car_q_sign, car_q_mag,
             early, prompt, late, dump_enable, status_read,
      input  i_early, q_early, i_prompt, q_prompt, i_late, q_late,
             sample_count, new_data, overrun
   );

   modport slave (
      input  ch_enable, acc_clear, sample_enable, if_sign, if_mag,
             car_i_sign, car_i_mag, car_q_sign, car_q_mag,
             early, prompt, late, dump_enable, status_read,
      output i_early, q_early, i_prompt, q_prompt, i_late, q_late,
             sample_count, new_data, overrun
   );
endinterface

// File: rtl/epl_correlator.sv
// Two-stage early/prompt/late correlator: mixes IF with carrier, despreads with
// code chips into six saturating accumulators, latches them on the code epoch.
module epl_correlator (
   input  logic            clk,
   input  logic            rst,
   epl_correlator_if.slave bus
);
   // Accumulator index order: 0 i_early, 1 q_early, 2 i_prompt, 3 q_prompt, 4 i_late, 5 q_late
   logic signed [3:0]  mix_i_q, mix_i_d, mix_q_q, mix_q_d;
   logic               early_q, early_d, prompt_q, prompt_d, late_q, late_d;
   logic               s1_valid_q, s1_valid_d;
   logic               dump_d_q, dump_d_d;
   logic signed [15:0] acc_q [6];
   logic signed [15:0] acc_d [6];
   logic signed [15:0] out_q [6];
   logic signed [15:0] out_d [6];
   logic [15:0]        cnt_q, cnt_d;
   logic [15:0]        count_out_q, count_out_d;
   logic               new_data_q, new_data_d;
   logic               overrun_q, overrun_d;
   logic signed [3:0]  contrib [6];
   logic               latch;

   function automatic logic signed [3:0] mult(input logic if_s, input logic if_m,
                                               input logic c_s, input logic c_m);
      logic [3:0] m;
      case ({if_m, c_m})
         2'b00:   m = 4'd1;
         2'b01:   m = 4'd2;
         2'b10:   m = 4'd3;
         default: m = 4'd6;
      endcase
      return (if_s ^ c_s) ? $signed(-m) : $signed(m);
   endfunction

   // Overflow shows up as bit 16 disagreeing with bit 15 of the widened sum
   function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [3:0]  b);
      logic signed [16:0] s;
      s = {a[15], a} + {{13{b[3]}}, b};
      if (!s[16] && s[15])      return 16'sh7FFF;
      else if (s[16] && !s[15]) return 16'sh8000;
      else                      return s[15:0];
   endfunction

   assign latch = bus.ch_enable & ~bus.acc_clear & dump_d_q;

   always_comb begin
      mix_i_d     = mix_i_q;
      mix_q_d     = mix_q_q;
      early_d     = early_q;
      prompt_d    = prompt_q;
      late_d      = late_q;
      s1_valid_d  = 1'b0;
      dump_d_d    = 1'b0;
      cnt_d       = cnt_q;
      count_out_d = count_out_q;
      new_data_d  = new_data_q;
      overrun_d   = overrun_q;
      for (int unsigned k = 0; k < 6; k++) begin
         acc_d[k]   = acc_q[k];
         out_d[k]   = out_q[k];
         contrib[k] = '0;
      end

      for (int unsigned k = 0; k < 6; k++) begin
         logic              chip;
         logic signed [3:0] mix;
         chip = (k < 2) ? early_q : ((k < 4) ? prompt_q : late_q);
         mix  = k[0] ? mix_q_q : mix_i_q;
         contrib[k] = chip ? -mix : mix;
      end

      if (bus.ch_enable && !bus.acc_clear) begin
         s1_valid_d = bus.sample_enable;
         dump_d_d   = bus.dump_enable;
         if (bus.sample_enable) begin
            mix_i_d  = mult(bus.if_sign, bus.if_mag, bus.car_i_sign, bus.car_i_mag);
            mix_q_d  = mult(bus.if_sign, bus.if_mag, bus.car_q_sign, bus.car_q_mag);
            early_d  = bus.early;
            prompt_d = bus.prompt;
            late_d   = bus.late;
         end
      end

      if (!bus.ch_enable || bus.acc_clear) begin
         cnt_d = '0;
         for (int unsigned k = 0; k < 6; k++) acc_d[k] = '0;
      end else if (latch) begin
         count_out_d = cnt_q;
         cnt_d       = {15'b0, s1_valid_q};
         for (int unsigned k = 0; k < 6; k++) begin
            out_d[k] = acc_q[k];
            acc_d[k] = s1_valid_q ? {{12{contrib[k][3]}}, contrib[k]} : '0;
         end
      end else if (s1_valid_q) begin
         if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
         for (int unsigned k = 0; k < 6; k++) acc_d[k] = sat_add(acc_q[k], contrib[k]);
      end

      if (latch) begin
         new_data_d = 1'b1;
         overrun_d  = ~bus.status_read & (overrun_q | new_data_q);
      end else if (bus.status_read) begin
         new_data_d = 1'b0;
         overrun_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mix_i_q     <= '0;
         mix_q_q     <= '0;
         early_q     <= 1'b0;
         prompt_q    <= 1'b0;
         late_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         dump_d_q    <= 1'b0;
         cnt_q       <= '0;
         count_out_q <= '0;
         new_data_q  <= 1'b0;
         overrun_q   <= 1'b0;
         for (int unsigned k = 0; k < 6; k++) begin
            acc_q[k] <= '0;
            out_q[k] <= '0;
         end
      end else begin
         mix_i_q     <= mix_i_d;
         mix_q_q     <= mix_q_d;
         early_q     <= early_d;
         prompt_q    <= prompt_d;
         late_q      <= late_d;
         s1_valid_q  <= s1_valid_d;
         dump_d_q    <= dump_d_d;
         cnt_q       <= cnt_d;
         count_out_q <= count_out_d;
         new_data_q  <= new_data_d;
         overrun_q   <= overrun_d;
         for (int unsigned k = 0; k < 6; k++) begin
            acc_q[k] <= acc_d[k];
            out_q[k] <= out_d[k];
         end
      end
   end

   assign bus.i_early      = out_q[0];
   assign bus.q_early      = out_q[1];
   assign bus.i_prompt     = out_q[2];
   assign bus.q_prompt     = out_q[3];
   assign bus.i_late       = out_q[4];
   assign bus.q_late       = out_q[5];
   assign bus.sample_count = count_out_q;
   assign bus.new_data     = new_data_q;
   assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_epl_correlator.sv
// Directed bench for epl_correlator: hand-computed correlation sums, dump
// alignment, saturation, status flags and control-input behaviour.
module tb_epl_correlator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   epl_correlator_if bus ();

   epl_correlator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic set_in(input logic ifs, input logic ifm, input logic cis, input logic cim,
                         input logic cqs, input logic cqm, input logic e, input logic p,
                         input logic l);
      bus.if_sign    = ifs;
      bus.if_mag     = ifm;
      bus.car_i_sign = cis;
      bus.car_i_mag  = cim;
      bus.car_q_sign = cqs;
      bus.car_q_mag  = cqm;
      bus.early      = e;
      bus.prompt     = p;
      bus.late       = l;
   endtask

   task automatic samples(input int n);
      bus.sample_enable = 1'b1;
      for (int i = 0; i < n; i++) tick();
      bus.sample_enable = 1'b0;
   endtask

   task automatic dump();
      bus.dump_enable = 1'b1;
      tick();
      bus.dump_enable = 1'b0;
      tick();
   endtask

   task automatic read_status();
      bus.status_read = 1'b1;
      tick();
      bus.status_read = 1'b0;
   endtask

   initial begin
      bus.ch_enable     = 1'b1;
      bus.acc_clear     = 1'b0;
      bus.sample_enable = 1'b0;
      bus.dump_enable   = 1'b0;
      bus.status_read   = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;

      chk("reset_i_early", bus.i_early, 16'd0);
      chk("reset_q_late", bus.q_late, 16'd0);
      chk("reset_count", bus.sample_count, 16'd0);
      chk("reset_new_data", {15'd0, bus.new_data}, 16'd0);
      chk("reset_overrun", {15'd0, bus.overrun}, 16'd0);

      // IF +3, carrier I +2, carrier Q +1: mix_i = 6, mix_q = 3
      set_in(0, 1, 0, 1, 0, 0, 0, 0, 0);
      samples(10);
      bus.dump_enable = 1'b1;
      tick();
      bus.dump_enable = 1'b0;
      chk("latch_t1_new_data", {15'd0, bus.new_data}, 16'd0);
      tick();
      chk("basic_i_early", bus.i_early, 16'd60);
      chk("basic_q_early", bus.q_early, 16'd30);
      chk("basic_i_prompt", bus.i_prompt, 16'd60);
      chk("basic_q_prompt", bus.q_prompt, 16'd30);
      chk("basic_i_late", bus.i_late, 16'd60);
      chk("basic_q_late", bus.q_late, 16'd30);
      chk("basic_count", bus.sample_count, 16'd10);
      chk("basic_new_data", {15'd0, bus.new_data}, 16'd1);
      chk("basic_overrun", {15'd0, bus.overrun}, 16'd0);
      read_status();
      chk("read_new_data", {15'd0, bus.new_data}, 16'd0);

      set_in(0, 1, 0, 1, 0, 0, 0, 0, 1);
      samples(10);
      dump();
      chk("late_i_late", bus.i_late, 16'(-60));
      chk("late_q_late", bus.q_late, 16'(-30));
      chk("late_i_early", bus.i_early, 16'd60);
      chk("late_q_prompt", bus.q_prompt, 16'd30);
      read_status();

      // sample coincident with dump belongs to the next interval
      set_in(0, 1, 0, 1, 0, 0, 0, 0, 0);
      samples(4);
      bus.sample_enable = 1'b1;
      bus.dump_enable   = 1'b1;
      tick();
      bus.sample_enable = 1'b0;
      bus.dump_enable   = 1'b0;
      tick();
      chk("align_count", bus.sample_count, 16'd4);
      chk("align_i_prompt", bus.i_prompt, 16'd24);
      read_status();
      dump();
      chk("align_next_count", bus.sample_count, 16'd1);
      chk("align_next_i_early", bus.i_early, 16'd6);
      chk("align_next_q_early", bus.q_early, 16'd3);
      read_status();

      samples(6000);
      dump();
      chk("sat_pos_i_early", bus.i_early, 16'h7FFF);
      chk("sat_pos_i_late", bus.i_late, 16'h7FFF);
      chk("sat_pos_q_early", bus.q_early, 16'd18000);
      chk("sat_pos_count", bus.sample_count, 16'd6000);
      read_status();
      set_in(1, 1, 0, 1, 0, 0, 0, 0, 0);
      samples(6000);
      dump();
      chk("sat_neg_i_prompt", bus.i_prompt, 16'h8000);
      chk("sat_neg_q_prompt", bus.q_prompt, 16'(-18000));
      read_status();

      set_in(0, 1, 0, 1, 0, 0, 0, 0, 0);
      samples(2);
      dump();
      chk("flag1_new_data", {15'd0, bus.new_data}, 16'd1);
      chk("flag1_overrun", {15'd0, bus.overrun}, 16'd0);
      dump();
      chk("flag2_overrun", {15'd0, bus.overrun}, 16'd1);
      chk("flag2_count", bus.sample_count, 16'd0);
      read_status();
      chk("flag_read_new_data", {15'd0, bus.new_data}, 16'd0);
      chk("flag_read_overrun", {15'd0, bus.overrun}, 16'd0);
      dump();
      bus.dump_enable = 1'b1;
      tick();
      bus.dump_enable = 1'b0;
      bus.status_read = 1'b1;
      tick();
      bus.status_read = 1'b0;
      chk("coinc_new_data", {15'd0, bus.new_data}, 16'd1);
      chk("coinc_overrun", {15'd0, bus.overrun}, 16'd0);
      read_status();

      samples(3);
      dump();
      chk("pre_rst_i_early", bus.i_early, 16'd18);
      samples(5);
      rst = 1'b1;
      bus.dump_enable = 1'b1;
      tick();
      rst = 1'b0;
      bus.dump_enable = 1'b0;
      tick();
      chk("rst_i_early", bus.i_early, 16'd0);
      chk("rst_count", bus.sample_count, 16'd0);
      chk("rst_new_data", {15'd0, bus.new_data}, 16'd0);
      chk("rst_overrun", {15'd0, bus.overrun}, 16'd0);

      samples(5);
      bus.acc_clear = 1'b1;
      tick();
      bus.acc_clear = 1'b0;
      samples(3);
      dump();
      chk("clr_count", bus.sample_count, 16'd3);
      chk("clr_i_early", bus.i_early, 16'd18);
      read_status();

      bus.ch_enable = 1'b0;
      samples(4);
      dump();
      chk("dis_count", bus.sample_count, 16'd3);
      chk("dis_q_late", bus.q_late, 16'd9);
      chk("dis_new_data", {15'd0, bus.new_data}, 16'd0);
      bus.ch_enable = 1'b1;
      tick();
      samples(2);
      dump();
      chk("reen_count", bus.sample_count, 16'd2);
      chk("reen_i_late", bus.i_late, 16'd12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
